// File: rtl/clock_set_ctrl.sv
// Time-of-day controller: 1 Hz prescaler, HH:MM:SS counter and a four-state
// set-mode FSM driven by single-cycle mode/inc button pulses.

module clock_set_ctrl_chk (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] hours,
    input  logic [5:0] mins,
    input  logic [5:0] secs,
    input  logic [1:0] mode,
    input  logic       tick
);

    // Registered outputs must stay in range; a tick only exists while running
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (hours <= 5'd23);
            assert (mins <= 6'd59);
            assert (secs <= 6'd59);
            assert (!(tick && (mode != 2'd0)));
        end
    end

endmodule

module clock_set_ctrl #(
    parameter int unsigned TICK_DIV = 100_000_000,
    parameter int unsigned CNT_W    = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [4:0] hours,
    output logic [5:0] mins,
    output logic [5:0] secs,
    output logic [1:0] mode,
    output logic       tick
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_SET_HR  = 2'd1,
        ST_SET_MIN = 2'd2,
        ST_SET_SEC = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] PRESC_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] PRESC_ONE  = CNT_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] presc_q, presc_d;
    logic [4:0]       hours_q, hours_d;
    logic [5:0]       mins_q,  mins_d;
    logic [5:0]       secs_q,  secs_d;
    logic             tick_q,  tick_d;
    logic             presc_done_s;
    logic             sec_wrap_s;
    logic             min_wrap_s;

    // ">=" rather than "==" folds any out-of-range value back to 0
    function automatic logic [4:0] inc_hours(input logic [4:0] v);
        if (v >= 5'd23) begin
            return 5'd0;
        end else begin
            return v + 5'd1;
        end
    endfunction

    function automatic logic [5:0] inc_sixty(input logic [5:0] v);
        if (v >= 6'd59) begin
            return 6'd0;
        end else begin
            return v + 6'd1;
        end
    endfunction

    assign presc_done_s = (presc_q >= PRESC_LAST);
    assign sec_wrap_s   = (secs_q >= 6'd59);
    assign min_wrap_s   = (mins_q >= 6'd59);

    // Next-state: a mode press outranks both inc and the prescaler terminal count
    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        hours_d = hours_q;
        mins_d  = mins_q;
        secs_d  = secs_q;
        tick_d  = 1'b0;

        if (btn_mode) begin
            presc_d = '0;
            case (state_q)
                ST_RUN:     state_d = ST_SET_HR;
                ST_SET_HR:  state_d = ST_SET_MIN;
                ST_SET_MIN: state_d = ST_SET_SEC;
                ST_SET_SEC: state_d = ST_RUN;
                default:    state_d = ST_RUN;
            endcase
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (presc_done_s) begin
                        presc_d = '0;
                        tick_d  = 1'b1;
                        secs_d  = inc_sixty(secs_q);
                        if (sec_wrap_s) begin
                            mins_d = inc_sixty(mins_q);
                        end else begin
                            mins_d = mins_q;
                        end
                        if (sec_wrap_s && min_wrap_s) begin
                            hours_d = inc_hours(hours_q);
                        end else begin
                            hours_d = hours_q;
                        end
                    end else begin
                        presc_d = presc_q + PRESC_ONE;
                    end
                end
                ST_SET_HR: begin
                    presc_d = '0;
                    if (btn_inc) begin
                        hours_d = inc_hours(hours_q);
                    end else begin
                        hours_d = hours_q;
                    end
                end
                ST_SET_MIN: begin
                    presc_d = '0;
                    if (btn_inc) begin
                        mins_d = inc_sixty(mins_q);
                    end else begin
                        mins_d = mins_q;
                    end
                end
                ST_SET_SEC: begin
                    presc_d = '0;
                    if (btn_inc) begin
                        secs_d = inc_sixty(secs_q);
                    end else begin
                        secs_d = secs_q;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                    presc_d = '0;
                end
            endcase
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
            presc_q <= '0;
            hours_q <= 5'd0;
            mins_q  <= 6'd0;
            secs_q  <= 6'd0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            hours_q <= hours_d;
            mins_q  <= mins_d;
            secs_q  <= secs_d;
            tick_q  <= tick_d;
        end
    end

    assign hours = hours_q;
    assign mins  = mins_q;
    assign secs  = secs_q;
    assign mode  = state_q;
    assign tick  = tick_q;

    clock_set_ctrl_chk u_chk (
        .clk   (clk),
        .reset (reset),
        .hours (hours_q),
        .mins  (mins_q),
        .secs  (secs_q),
        .mode  (state_q),
        .tick  (tick_q)
    );

endmodule
